// File: rtl/mul_issue_if.sv
// mul_issue_if: issue-side and writeback-side handshake bundle for mul_issue.
//
//   Issue channel   : in_valid, in_ready, in_op, in_src1, in_src2, in_dest, in_tag
//   Writeback channel: out_valid, out_ready, out_data, out_dest, out_tag
//
//   master modport : the surrounding pipeline (issue drives in_*, writeback
//                    drives out_ready)
//   slave modport  : the mul_issue block itself
interface mul_issue_if #(
  parameter int TAG_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [31:0]      in_src1;
  logic [31:0]      in_src2;
  logic [4:0]       in_dest;
  logic [TAG_W-1:0] in_tag;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic [4:0]       out_dest;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_op, in_src1, in_src2, in_dest, in_tag,
    input  in_ready,
    input  out_valid, out_data, out_dest, out_tag,
    output out_ready
  );

  modport slave (
    input  in_valid, in_op, in_src1, in_src2, in_dest, in_tag,
    output in_ready,
    output out_valid, out_data, out_dest, out_tag,
    input  out_ready
  );
endinterface

// File: rtl/mul_issue.sv
// mul_issue: execute-stage front end for the two-stage Booth/Wallace
// multiplier core. Accepts MUL.W / MULH.W / MULH.WU from issue, drives the
// core operands, tracks the single op whose operands the core sampled (S1),
// selects the 32-bit result half and holds it in a registered output buffer
// (OUT) with full backpressure. Sustains one op per cycle.
//
// Ports:
//   mul_clk, reset     clock; synchronous active-high reset
//   io (slave)         issue channel in_* and writeback channel out_*
//   flush              discard S1 and OUT; blocks accept this cycle
//   mul_x, mul_y       core operands (sampled by the core on mul_clk)
//   mul_signed         core sign mode (1 only for MULH.W)
//   mul_result         core 64-bit product, valid the cycle after sampling
//   stall_cnt          saturating count of cycles with out_valid & ~out_ready
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid and ready are both 1. A producer holding valid must keep its
// payload stable until the transfer; valid never depends on ready. Here
// in_ready depends only on reset, flush and internal state, and out_valid /
// out_* come straight from registers.
module mul_issue #(
  parameter int TAG_W = 32,
  parameter int CNT_W = 32
) (
  input  logic             mul_clk,
  input  logic             reset,
  input  logic             flush,
  mul_issue_if.slave       io,
  output logic [31:0]      mul_x,
  output logic [31:0]      mul_y,
  output logic             mul_signed,
  input  logic [63:0]      mul_result,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] OP_MULH  = 2'b01;
  localparam logic [1:0] OP_MULHU = 2'b10;

  // S1 slot: op whose operands the core sampled at the last edge
  logic             s1Valid;
  logic [1:0]       s1Op;
  logic [4:0]       s1Dest;
  logic [TAG_W-1:0] s1Tag;

  // Copies of the last accepted operands; re-driven while S1 is stalled so
  // the core keeps producing the same product.
  logic [31:0]      holdX;
  logic [31:0]      holdY;
  logic             holdSigned;

  // OUT buffer
  logic             outValid;
  logic [31:0]      outData;
  logic [4:0]       outDest;
  logic [TAG_W-1:0] outTag;

  logic [CNT_W-1:0] stallCnt;

  logic             advance;
  logic             inReady;
  logic             accept;
  logic             inSigned;
  logic [31:0]      selData;

  assign advance  = ~outValid | io.out_ready;
  assign inReady  = ~reset & ~flush & (~s1Valid | advance);
  assign accept   = io.in_valid & inReady;
  assign inSigned = (io.in_op == OP_MULH);

  always_comb begin
    mul_x      = holdX;
    mul_y      = holdY;
    mul_signed = holdSigned;
    if (accept) begin
      mul_x      = io.in_src1;
      mul_y      = io.in_src2;
      mul_signed = inSigned;
    end
  end

  // High half for MULH.W / MULH.WU, low half for MUL.W (and op 11)
  always_comb begin
    selData = mul_result[31:0];
    if (s1Op == OP_MULH || s1Op == OP_MULHU) begin
      selData = mul_result[63:32];
    end
  end

  always_ff @(posedge mul_clk) begin
    if (reset) begin
      s1Valid    <= 1'b0;
      s1Op       <= 2'b00;
      s1Dest     <= '0;
      s1Tag      <= '0;
      holdX      <= '0;
      holdY      <= '0;
      holdSigned <= 1'b0;
      outValid   <= 1'b0;
      outData    <= '0;
      outDest    <= '0;
      outTag     <= '0;
      stallCnt   <= '0;
    end else begin
      if (accept) begin
        holdX      <= io.in_src1;
        holdY      <= io.in_src2;
        holdSigned <= inSigned;
      end

      if (outValid && !io.out_ready && stallCnt != '1) begin
        stallCnt <= stallCnt + 1'b1;
      end

      if (flush) begin
        // Only the valid bits are dropped; payload fields are don't-care
        s1Valid  <= 1'b0;
        outValid <= 1'b0;
      end else begin
        // Loading OUT from S1 while OUT drains keeps out_valid high
        if (s1Valid && advance) begin
          outValid <= 1'b1;
          outData  <= selData;
          outDest  <= s1Dest;
          outTag   <= s1Tag;
        end else if (outValid && io.out_ready) begin
          outValid <= 1'b0;
        end

        if (accept) begin
          s1Valid <= 1'b1;
          s1Op    <= io.in_op;
          s1Dest  <= io.in_dest;
          s1Tag   <= io.in_tag;
        end else if (advance) begin
          s1Valid <= 1'b0;
        end
      end
    end
  end

  assign io.in_ready  = inReady;
  assign io.out_valid = outValid;
  assign io.out_data  = outData;
  assign io.out_dest  = outDest;
  assign io.out_tag   = outTag;
  assign stall_cnt    = stallCnt;

endmodule

// File: tb/tb_mul_issue.sv
// tb_mul_issue: directed bench for mul_issue with a behavioural two-stage
// multiplier core (operands sampled on mul_clk, product held the next cycle).
module tb_mul_issue;
  localparam int TAG_W = 32;
  localparam int CNT_W = 32;

  // ---------------- clock / reset ----------------
  logic             mul_clk = 1'b0;
  logic             reset;
  logic             flush;
  logic [31:0]      mul_x;
  logic [31:0]      mul_y;
  logic             mul_signed;
  logic [63:0]      mul_result;
  logic [CNT_W-1:0] stall_cnt;

  always #5 mul_clk = ~mul_clk;

  mul_issue_if #(.TAG_W(TAG_W)) io ();

  mul_issue #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .flush      (flush),
    .io         (io.slave),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .stall_cnt  (stall_cnt)
  );

  // Core model: sign-extend only in signed mode; low 64 bits of the 64x64
  // product equal the 32x32 product.
  always @(posedge mul_clk) begin
    mul_result <= {{32{mul_x[31] & mul_signed}}, mul_x} *
                  {{32{mul_y[31] & mul_signed}}, mul_y};
  end

  int checks = 0;
  int errors = 0;

  // Watchdog: the bench never waits on DUT events, but guard anyway
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge mul_clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
    io.in_valid = 1'b1;
    io.in_op    = op;
    io.in_src1  = a;
    io.in_src2  = b;
    io.in_dest  = tag[4:0];
    io.in_tag   = tag;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; flush = 1'b0;
    io.in_valid = 1'b1; io.in_op = 2'b00; io.in_src1 = 32'h1234; io.in_src2 = 32'h5678;
    io.in_dest = 5'd0; io.in_tag = '0; io.out_ready = 1'b1;
    step(); step();
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", io.in_ready); end
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", io.out_valid); end
    checks++; if (io.out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data got %h exp 0", io.out_data); end
    checks++; if (io.out_dest !== 5'h0) begin errors++; $display("FAIL rst_out_dest got %h exp 0", io.out_dest); end
    checks++; if (io.out_tag !== '0) begin errors++; $display("FAIL rst_out_tag got %h exp 0", io.out_tag); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL rst_stall_cnt got %0d exp 0", stall_cnt); end
    checks++; if (mul_x !== 32'h0 || mul_y !== 32'h0) begin errors++; $display("FAIL rst_hold got %h/%h exp 0/0", mul_x, mul_y); end
    reset = 1'b0; io.in_valid = 1'b0;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", io.in_ready); end
    step();
  endtask

  task automatic test_single(input string name, input logic [1:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp, input logic [TAG_W-1:0] tag);
    io.out_ready = 1'b1;
    drive(op, a, b, tag);
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL %s in_ready got %b exp 1", name, io.in_ready); end
    checks++; if (mul_signed !== (op == 2'b01)) begin errors++; $display("FAIL %s mul_signed got %b exp %b", name, mul_signed, op == 2'b01); end
    checks++; if (mul_x !== a || mul_y !== b) begin errors++; $display("FAIL %s operands got %h/%h exp %h/%h", name, mul_x, mul_y, a, b); end
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL %s early_valid got %b exp 0", name, io.out_valid); end
    step();
    checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL %s out_valid got %b exp 1", name, io.out_valid); end
    checks++; if (io.out_data !== exp) begin errors++; $display("FAIL %s out_data got %h exp %h", name, io.out_data, exp); end
    checks++; if (io.out_tag !== tag || io.out_dest !== tag[4:0]) begin errors++; $display("FAIL %s tag/dest got %h/%h exp %h/%h", name, io.out_tag, io.out_dest, tag, tag[4:0]); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL %s drain got %b exp 0", name, io.out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp;
    io.out_ready = 1'b1;
    for (int c = 0; c < 7; c++) begin
      // Outputs for ops issued two cycles earlier
      if (c >= 2 && c <= 5) begin
        exp = exp_q.pop_front();
        checks++; if (io.out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid c=%0d got %b exp 1", c, io.out_valid); end
        checks++; if (io.out_tag !== TAG_W'(c - 1)) begin errors++; $display("FAIL b2b_tag c=%0d got %0d exp %0d", c, io.out_tag, c - 1); end
        checks++; if (io.out_data !== exp) begin errors++; $display("FAIL b2b_data c=%0d got %h exp %h", c, io.out_data, exp); end
      end else begin
        checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle c=%0d got %b exp 0", c, io.out_valid); end
      end
      if (c < 4) begin
        drive(2'b00, 32'(c + 1), 32'd3, TAG_W'(c + 1));
        exp_q.push_back(32'(3 * (c + 1)));
        #1;
        checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready c=%0d got %b exp 1", c, io.in_ready); end
      end else begin
        io.in_valid = 1'b0;
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    io.out_ready = 1'b0;
    drive(2'b10, 32'h7, 32'hFFFFFFFD, 11);          // MULH.WU -> 6
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0 got %b exp 1", io.in_ready); end
    step();
    drive(2'b00, 32'h7, 32'hFFFFFFFD, 12);          // MUL.W -> FFFFFFEB
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1 got %b exp 1", io.in_ready); end
    step();
    drive(2'b01, 32'h80000000, 32'h80000000, 13);   // MULH.W -> 40000000
    for (int c = 2; c <= 6; c++) begin
      #1;
      checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL bp_blocked c=%0d got %b exp 0", c, io.in_ready); end
      checks++; if (io.out_valid !== 1'b1 || io.out_tag !== 11 || io.out_data !== 32'h6 || io.out_dest !== 5'd11)
        begin errors++; $display("FAIL bp_hold c=%0d got v=%b tag=%0d data=%h dest=%0d exp v=1 tag=11 data=6 dest=11", c, io.out_valid, io.out_tag, io.out_data, io.out_dest); end
      checks++; if (stall_cnt !== CNT_W'(c - 2)) begin errors++; $display("FAIL bp_stall c=%0d got %0d exp %0d", c, stall_cnt, c - 2); end
      step();
    end
    checks++; if (stall_cnt !== 5) begin errors++; $display("FAIL bp_stall_total got %0d exp 5", stall_cnt); end
    io.out_ready = 1'b1;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", io.in_ready); end
    checks++; if (io.out_valid !== 1'b1 || io.out_tag !== 11) begin errors++; $display("FAIL bp_out_a got v=%b tag=%0d exp v=1 tag=11", io.out_valid, io.out_tag); end
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b1 || io.out_tag !== 12 || io.out_data !== 32'hFFFFFFEB) begin errors++; $display("FAIL bp_out_b got v=%b tag=%0d data=%h exp v=1 tag=12 data=ffffffeb", io.out_valid, io.out_tag, io.out_data); end
    step();
    checks++; if (io.out_valid !== 1'b1 || io.out_tag !== 13 || io.out_data !== 32'h40000000) begin errors++; $display("FAIL bp_out_c got v=%b tag=%0d data=%h exp v=1 tag=13 data=40000000", io.out_valid, io.out_tag, io.out_data); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b exp 0", io.out_valid); end
    checks++; if (stall_cnt !== 5) begin errors++; $display("FAIL bp_stall_kept got %0d exp 5", stall_cnt); end
  endtask

  task automatic test_flush();
    io.out_ready = 1'b0;
    drive(2'b00, 32'h5, 32'h5, 21);
    step();
    drive(2'b00, 32'h6, 32'h6, 22);
    step();
    // S1 and OUT both full now
    checks++; if (io.out_valid !== 1'b1 || io.out_tag !== 21) begin errors++; $display("FAIL fl_pre got v=%b tag=%0d exp v=1 tag=21", io.out_valid, io.out_tag); end
    drive(2'b00, 32'h9, 32'h9, 29);
    flush = 1'b1;
    #1;
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL fl_ready got %b exp 0", io.in_ready); end
    step();
    flush = 1'b0;
    io.out_ready = 1'b1;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL fl_cleared got %b exp 0", io.out_valid); end
    checks++; if (stall_cnt !== 6) begin errors++; $display("FAIL fl_stall got %0d exp 6", stall_cnt); end
    drive(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 23);  // MUL.W -> 1
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL fl_after_ready got %b exp 1", io.in_ready); end
    step();
    io.in_valid = 1'b0;
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL fl_no_stale got %b exp 0", io.out_valid); end
    step();
    checks++; if (io.out_valid !== 1'b1 || io.out_tag !== 23 || io.out_data !== 32'h1) begin errors++; $display("FAIL fl_next_op got v=%b tag=%0d data=%h exp v=1 tag=23 data=1", io.out_valid, io.out_tag, io.out_data); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL fl_drain got %b exp 0", io.out_valid); end
  endtask

  task automatic test_reset_inflight();
    io.out_ready = 1'b0;
    drive(2'b01, 32'h7, 32'hFFFFFFFD, 31);
    step();
    drive(2'b10, 32'h7, 32'hFFFFFFFD, 32);
    step();
    checks++; if (io.out_valid !== 1'b1 || stall_cnt !== 6) begin errors++; $display("FAIL ri_pre got v=%b stall=%0d exp v=1 stall=6", io.out_valid, stall_cnt); end
    reset = 1'b1;
    #1;
    checks++; if (io.in_ready !== 1'b0) begin errors++; $display("FAIL ri_ready_in_reset got %b exp 0", io.in_ready); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL ri_out_valid got %b exp 0", io.out_valid); end
    checks++; if (stall_cnt !== 0) begin errors++; $display("FAIL ri_stall got %0d exp 0", stall_cnt); end
    checks++; if (io.out_tag !== 0 || io.out_data !== 0) begin errors++; $display("FAIL ri_fields got tag=%0d data=%h exp 0/0", io.out_tag, io.out_data); end
    reset = 1'b0;
    io.in_valid = 1'b0;
    io.out_ready = 1'b1;
    #1;
    checks++; if (io.in_ready !== 1'b1) begin errors++; $display("FAIL ri_ready_after got %b exp 1", io.in_ready); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL ri_no_ghost1 got %b exp 0", io.out_valid); end
    step();
    checks++; if (io.out_valid !== 1'b0) begin errors++; $display("FAIL ri_no_ghost2 got %b exp 0", io.out_valid); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_single("mulw_7",    2'b00, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    test_single("mulhw_7",   2'b01, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFFF, 2);
    test_single("mulhwu_7",  2'b10, 32'h7, 32'hFFFFFFFD, 32'h00000006, 3);
    test_single("op11_7",    2'b11, 32'h7, 32'hFFFFFFFD, 32'hFFFFFFEB, 4);
    test_single("mulhw_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 5);
    test_single("mulhwu_min",2'b10, 32'h80000000, 32'h80000000, 32'h40000000, 6);
    test_single("mulw_min",  2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 7);
    test_single("mulhw_m1",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 8);
    test_single("mulhwu_m1", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 9);
    test_single("mulw_m1",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 10);
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_inflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
